// File: rtl/demux_1x5_buf.sv
// demux_1x5_buf
//   Buffered 1-to-5 demultiplexer. Each input word carries a 3-bit lane
//   select (0=a, 1=b, 2=c, 3=d, 4=e) and is captured into a one-entry
//   register for that lane. Words with an illegal select (5..7) are always
//   accepted, discarded, and reported through err_sel / err_count.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_data    word to route (width bits)
//   in_sel     destination lane, 0..4 legal
//   in_valid   source has a word
//   in_ready   word is accepted this cycle (combinational from in_sel/out_ready)
//   out_a..e   registered lane data
//   out_valid  bit i = lane i register full
//   out_ready  bit i = lane i consumer takes the word this cycle
//   err_sel    registered one-cycle pulse after an illegal-select accept
//   err_count  saturating count of accepted illegal-select words
module demux_1x5_buf #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] in_data,
  input  logic [2:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [width-1:0] out_a,
  output logic [width-1:0] out_b,
  output logic [width-1:0] out_c,
  output logic [width-1:0] out_d,
  output logic [width-1:0] out_e,
  output logic [4:0]       out_valid,
  input  logic [4:0]       out_ready,
  output logic             err_sel,
  output logic [7:0]       err_count
);

  localparam int NUM_LANES = 5;

  logic [NUM_LANES-1:0]            full;
  logic [NUM_LANES-1:0][width-1:0] lane_data;
  logic                            sel_legal;
  logic                            lane_ready;
  logic                            accept;

  logic       err_sel_q, err_sel_d;
  logic [7:0] err_count_q, err_count_d;

  // Ready is decoded with an explicit case so an illegal select never
  // indexes past the lane vectors; illegal words are always taken.
  always_comb begin
    sel_legal  = 1'b0;
    lane_ready = 1'b1;
    case (in_sel)
      3'd0: begin sel_legal = 1'b1; lane_ready = ~full[0] | out_ready[0]; end
      3'd1: begin sel_legal = 1'b1; lane_ready = ~full[1] | out_ready[1]; end
      3'd2: begin sel_legal = 1'b1; lane_ready = ~full[2] | out_ready[2]; end
      3'd3: begin sel_legal = 1'b1; lane_ready = ~full[3] | out_ready[3]; end
      3'd4: begin sel_legal = 1'b1; lane_ready = ~full[4] | out_ready[4]; end
      default: begin sel_legal = 1'b0; lane_ready = 1'b1; end
    endcase
  end

  assign in_ready = lane_ready;
  assign accept   = in_valid & lane_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic             full_q, full_d;
      logic [width-1:0] data_q, data_d;
      logic             load;
      logic             drain;

      // Load wins over drain: on a simultaneous load+drain the old word
      // leaves this cycle and the new one is held, full stays set.
      always_comb begin
        load   = accept & sel_legal & (in_sel == 3'(gi));
        drain  = full_q & out_ready[gi];
        full_d = full_q;
        data_d = data_q;
        if (load) begin
          full_d = 1'b1;
          data_d = in_data;
        end else if (drain) begin
          full_d = 1'b0;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          full_q <= 1'b0;
          data_q <= '0;
        end else begin
          full_q <= full_d;
          data_q <= data_d;
        end
      end

      assign full[gi]      = full_q;
      assign lane_data[gi] = data_q;
    end
  endgenerate

  always_comb begin
    err_sel_d   = accept & ~sel_legal;
    err_count_d = err_count_q;
    if (err_sel_d && (err_count_q != 8'hff)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sel_q   <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      err_sel_q   <= err_sel_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = full;
  assign out_a     = lane_data[0];
  assign out_b     = lane_data[1];
  assign out_c     = lane_data[2];
  assign out_d     = lane_data[3];
  assign out_e     = lane_data[4];
  assign err_sel   = err_sel_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_demux_1x5_buf.sv
module tb_demux_1x5_buf;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic [2:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_a, out_b, out_c, out_d, out_e;
  logic [4:0]  out_valid;
  logic [4:0]  out_ready;
  logic        err_sel;
  logic [7:0]  err_count;

  int vectors;
  int miscompares;

  demux_1x5_buf #(.width(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_d     (out_d),
    .out_e     (out_e),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_sel   (err_sel),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst       = 1'b1;
    in_data   = '0;
    in_sel    = '0;
    in_valid  = 1'b0;
    out_ready = '0;

    // Reset state
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_err_count", 32'(err_count), 32'h0);
    chk("rst_err_sel", 32'(err_sel), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    step(); step();
    rst = 1'b0;
    step();

    // Basic routing: one word per lane, no consumer
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_sel   = 3'(i);
      in_data  = 32'h11111111 * (i + 1);
      #1;
      chk($sformatf("route_ready_%0d", i), 32'(in_ready), 32'h1);
      step();
      chk($sformatf("route_valid_%0d", i), 32'(out_valid), 32'((1 << (i + 1)) - 1));
    end
    in_valid = 1'b0;
    chk("route_a", out_a, 32'h11111111);
    chk("route_b", out_b, 32'h22222222);
    chk("route_c", out_c, 32'h33333333);
    chk("route_d", out_d, 32'h44444444);
    chk("route_e", out_e, 32'h55555555);
    // Sixth word to full lane c is refused
    in_valid = 1'b1;
    in_sel   = 3'd2;
    in_data  = 32'h66666666;
    #1;
    chk("full_c_ready", 32'(in_ready), 32'h0);
    step();
    in_valid = 1'b0;
    chk("full_c_hold", out_c, 32'h33333333);

    // Drain everything
    out_ready = 5'b11111;
    step();
    out_ready = 5'b00000;
    chk("drain_all", 32'(out_valid), 32'h0);

    // Backpressure pass-through on lane c
    in_valid = 1'b1; in_sel = 3'd2; in_data = 32'hAAAA0000;
    step();
    chk("pt_first_c", out_c, 32'hAAAA0000);
    chk("pt_first_valid", 32'(out_valid), 32'h04);
    out_ready = 5'b00100;
    in_data   = 32'hBBBB0000;
    #1;
    chk("pt_ready", 32'(in_ready), 32'h1);
    chk("pt_emit_c", out_c, 32'hAAAA0000);
    step();
    in_valid  = 1'b0;
    out_ready = 5'b00000;
    chk("pt_second_c", out_c, 32'hBBBB0000);
    chk("pt_valid_held", 32'(out_valid), 32'h04);

    // Lane isolation: a stalled, e streaming
    out_ready = 5'b00100;
    step();
    out_ready = 5'b00000;
    in_valid = 1'b1; in_sel = 3'd0; in_data = 32'h12345678;
    step();
    out_ready = 5'b10000;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_sel   = 3'd4;
      in_data  = 32'hE0000000 + 32'(k);
      #1;
      chk($sformatf("iso_ready_%0d", k), 32'(in_ready), 32'h1);
      step();
      chk($sformatf("iso_e_%0d", k), out_e, 32'hE0000000 + 32'(k));
      chk($sformatf("iso_valid_%0d", k), 32'(out_valid), 32'h11);
    end
    in_valid = 1'b0;
    step();
    out_ready = 5'b00000;
    chk("iso_e_drained", 32'(out_valid), 32'h01);
    chk("iso_a_kept", out_a, 32'h12345678);

    // Illegal selects back-to-back
    in_data = 32'hDEADBEEF;
    for (int k = 5; k < 8; k++) begin
      in_valid = 1'b1;
      in_sel   = 3'(k);
      #1;
      chk($sformatf("ill_ready_%0d", k), 32'(in_ready), 32'h1);
      step();
      chk($sformatf("ill_err_sel_%0d", k), 32'(err_sel), 32'h1);
      chk($sformatf("ill_valid_%0d", k), 32'(out_valid), 32'h01);
    end
    in_valid = 1'b0;
    chk("ill_count", 32'(err_count), 32'h3);
    chk("ill_a_untouched", out_a, 32'h12345678);
    step();
    chk("ill_err_sel_low", 32'(err_sel), 32'h0);

    // Saturation: 300 more illegal words
    for (int k = 0; k < 300; k++) begin
      in_valid = 1'b1;
      in_sel   = 3'(5 + (k % 3));
      step();
    end
    chk("sat_count", 32'(err_count), 32'hFF);
    chk("sat_err_sel", 32'(err_sel), 32'h1);
    in_valid = 1'b0;
    step();
    chk("sat_err_sel_low", 32'(err_sel), 32'h0);
    chk("sat_count_hold", 32'(err_count), 32'hFF);
    in_valid = 1'b1; in_sel = 3'd1; in_data = 32'hB0B0B0B0;
    step();
    in_valid = 1'b0;
    chk("sat_legal_b", out_b, 32'hB0B0B0B0);
    chk("sat_legal_valid", 32'(out_valid), 32'h03);

    // Reset mid-run with b and d full
    out_ready = 5'b00001;
    in_valid = 1'b1; in_sel = 3'd3; in_data = 32'hD0D0D0D0;
    step();
    in_valid  = 1'b0;
    out_ready = 5'b00000;
    chk("mid_pre_valid", 32'(out_valid), 32'h0A);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_count", 32'(err_count), 32'h0);
    chk("mid_rst_b", out_b, 32'h0);
    chk("mid_rst_d", out_d, 32'h0);
    chk("mid_rst_a", out_a, 32'h0);
    chk("mid_rst_ready", 32'(in_ready), 32'h1);
    step();
    rst = 1'b0;
    in_valid = 1'b1; in_sel = 3'd3; in_data = 32'h00000077;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    chk("post_rst_d", out_d, 32'h00000077);
    chk("post_rst_valid", 32'(out_valid), 32'h08);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/demux_1x5_buf.md
# demux_1x5_buf

Buffered 1-to-5 demultiplexer with valid/ready handshakes. It is the distribution counterpart of the 5-input select mux used in the datapath. It accepts one `width`-bit word per cycle tagged with a 3-bit lane select, using the same encoding as the mux: 0=a, 1=b, 2=c, 3=d, 4=e. Each word lands in a one-entry output register for the selected lane. Words carrying an illegal select (5–7) are consumed and dropped, and counted as errors.

## Interface
- `width`, default 32, data word width in bits.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  width  word to route.
- `in_sel`  in  3  destination lane; 0..4 legal, 5..7 illegal.
- `in_valid`  in  1  source has a word.
- `in_ready`  out  1  block accepts the word this cycle (combinational).
- `out_a`, `out_b`, `out_c`, `out_d`, `out_e`  out  width each  registered lane data.
- `out_valid`  out  5  bit i high = lane i register full (bit 0 = a … bit 4 = e).
- `out_ready`  in  5  bit i high = lane i consumer takes the word this cycle.
- `err_sel`  out  1  one-cycle pulse, registered, after an illegal-select word was accepted.
- `err_count`  out  8  saturating count of accepted illegal-select words.

## Operation
- **Per-lane state:** `full[i]` flag plus `data[i]` register; `out_valid[i] = full[i]`; lane output = `data[i]`.
- **Accept:** `accept = in_valid & in_ready`.
- **Ready, legal `in_sel = s`:** `in_ready = ~full[s] | out_ready[s]`. This is a pass-through of the consumer's ready, so a full lane being drained accepts a new word in the same cycle.
- **Ready, illegal `in_sel`:** `in_ready = 1`. The word is discarded, no lane changes, `err_sel` pulses the next cycle, and `err_count` increments (holds at 255).
- **Lane update per cycle:**
  - load = accept & legal & (`in_sel` == i);
  - drain = `full[i] & out_ready[i]`;
  - load → `data[i] <= in_data`, `full[i] <= 1`;
  - else drain → `full[i] <= 0`, data held;
  - else no change.
  - Simultaneous load+drain: old word leaves, new word stored, `full` stays 1.
- **Lane independence:** lanes are fully independent; a stalled lane never blocks traffic to other lanes.
- **Illegal-select data:** `in_data` on an illegal select never reaches any output.
- **Ordering:** per-lane order is preserved; there is no reordering because depth is 1.
- **Undriven inputs:** `in_sel` and `in_data` are ignored when `in_valid` = 0; `in_ready` may still toggle with `in_sel`.
- **Data while not valid:** lane data while `out_valid[i]` = 0 is the last stored word (or 0 after reset); consumers must not rely on it.

## Timing
- **Reset (async assert, immediate):** `full` = 0 for all lanes, all lane data = 0, `out_valid` = 5'b00000, `err_sel` = 0, `err_count` = 0.
- **Ready during reset:** `in_ready` during reset follows the equations above with `full` = 0, so it reads 1. No transfer occurs while `rst` is high.
- **Latency:** word accepted in cycle N appears on its lane with `out_valid` high in cycle N+1.
- **Throughput:** one word per cycle sustained to one lane if that lane's `out_ready` is held high. Interleaving across lanes is also full rate.
- **Error pulse:** `err_sel` is high exactly in cycle N+1 for an illegal accept in cycle N. Back-to-back illegal words hold it high.
- **Reset mid-operation:** buffered words are lost, with no partial state. The first accept is possible in the first cycle after `rst` deasserts.
- **No combinational paths except:** `out_ready` → `in_ready`, and `in_sel` → `in_ready`.

## Test plan
- **Reset:** drive `rst` = 1 mid-run with lanes b and d full → `out_valid` = 0 immediately, `err_count` = 0, all lane data 0; after release, `in_ready` = 1.
- **Basic routing:** send 0x11111111..0x55555555 with `in_sel` 0..4, `out_ready` = 0 → next cycles `out_valid` fills to 5'b11111; each lane holds its word; a 6th word to lane 2 sees `in_ready` = 0.
- **Backpressure pass-through:** lane c full with 0xAAAA0000, `out_ready[2]` = 1, new word 0xBBBB0000 to c in the same cycle → `in_ready` = 1; lane c emits 0xAAAA0000 that cycle and holds 0xBBBB0000 next, with `out_valid[2]` continuously 1.
- **Lane isolation:** lane a full with `out_ready[0]` = 0, stream 4 words to lane e with `out_ready[4]` = 1 → all 4 delivered at 1/cycle; lane a unchanged.
- **Illegal selects:** send `in_sel` = 5, 6, 7 back-to-back → `in_ready` = 1 each cycle, no `out_valid` change, `err_sel` high for 3 cycles, `err_count` = 3.
- **Saturation:** send 300 illegal words → `err_count` stops at 255; `err_sel` still pulses; legal traffic is still routed correctly afterwards.
